// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-port memory arbiter.
//   state_t     : arbiter FSM states
//   NUM_REQ     : number of requester ports
//   DEF_DATA_W  : default data width
//   DEF_ADDR_W  : default address width
//   other_req() : index of the requester that is not `idx`
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int NUM_REQ    = 2;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  function automatic logic other_req(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundle of the two requester ports and the memory port of mem_arbiter.
//   Requester n : reqn, wen, addrn, wdatan (in)  / gntn, rvalidn, rdatan (out)
//   Memory      : mem_rd_en, mem_wr_en, mem_addr, mem_wdata (out) / mem_rdata (in)
// Modports:
//   slave  : arbiter side
//   master : environment side (requesters + memory)
// -----------------------------------------------------------------------------
interface mem_arbiter_if import mem_arb_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;

  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_rd_en, mem_wr_en, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_rd_en, mem_wr_en, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin winner selection (purely combinational).
//   req    (in)  : request vector, bit n = requester n
//   ptr    (in)  : favoured requester when both request
//   winner (out) : index of the selected requester (valid when any = 1)
//   any    (out) : at least one request is present
// -----------------------------------------------------------------------------
module rr_arb2 import mem_arb_pkg::*; (
  input  logic [NUM_REQ-1:0] req,
  input  logic               ptr,
  output logic               winner,
  output logic               any
);

  always_comb begin
    any    = |req;
    winner = ptr;
    // A lone requester wins whatever the pointer says.
    if (req == 2'b01) begin
      winner = 1'b0;
    end else if (req == 2'b10) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Round-robin arbiter giving two requesters access to one single-port memory.
// A request sampled in IDLE is registered and issued to memory in the next
// cycle (ACCESS, gnt pulse). Reads spend one extra cycle in RD_WAIT while the
// memory returns data; the data is captured and flagged with rvalid the
// cycle after.
//   clk   (in) : clock, rising edge
//   reset (in) : synchronous, active low
//   bus        : mem_arbiter_if.slave, requester and memory ports
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no access in flight; arbitrate among present requests
// ACCESS  | issue registered access to memory, pulse winner's gnt
// RD_WAIT | memory read data valid; capture into winner's rdata
// -----------------------------------------------------------------------------
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic       clk,
  input  logic       reset,
  mem_arbiter_if.slave bus
);

  state_t state_q;
  state_t state_d;

  logic               ptr_q;
  logic               winner_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [NUM_REQ-1:0] rvalid_q;
  logic [DATA_W-1:0]  rdata0_q;
  logic [DATA_W-1:0]  rdata1_q;

  logic [NUM_REQ-1:0] req_vec;
  logic               arb_winner;
  logic               arb_any;

  logic               take;
  logic               capture;
  logic [NUM_REQ-1:0] gnt_vec;
  logic               rd_en;
  logic               wr_en;

  assign req_vec = {bus.req1, bus.req0};

  rr_arb2 u_rr_arb2 (
    .req    (req_vec),
    .ptr    (ptr_q),
    .winner (arb_winner),
    .any    (arb_any)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    capture = 1'b0;
    gnt_vec = '0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          take    = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        gnt_vec[winner_q] = 1'b1;
        if (we_q) begin
          wr_en   = 1'b1;
          state_d = IDLE;
        end else begin
          rd_en   = 1'b1;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        capture = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Access registers double as the memory address/data outputs, so they
  // only change when a new access is taken and otherwise hold their value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q    <= 1'b0;
      winner_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q <= '0;
      if (take) begin
        winner_q <= arb_winner;
        ptr_q    <= other_req(arb_winner);
        we_q     <= arb_winner ? bus.we1    : bus.we0;
        addr_q   <= arb_winner ? bus.addr1  : bus.addr0;
        wdata_q  <= arb_winner ? bus.wdata1 : bus.wdata0;
      end
      if (capture) begin
        if (winner_q) begin
          rdata1_q    <= bus.mem_rdata;
          rvalid_q[1] <= 1'b1;
        end else begin
          rdata0_q    <= bus.mem_rdata;
          rvalid_q[0] <= 1'b1;
        end
      end
    end
  end

  assign bus.gnt0      = gnt_vec[0];
  assign bus.gnt1      = gnt_vec[1];
  assign bus.rvalid0   = rvalid_q[0];
  assign bus.rvalid1   = rvalid_q[1];
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_rd_en = rd_en;
  assign bus.mem_wr_en = wr_en;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: hand sequences for latency, contention,
// late request and reset abort, plus a table of simultaneous-request vectors.
// Expected grants and read data are queued when stimulus is driven and
// popped by a monitor when the DUT produces gnt / rvalid.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  mem_arbiter #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       idx;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
  } gnt_exp_t;

  typedef struct {
    logic       idx;
    logic [7:0] data;
  } rd_exp_t;

  typedef struct {
    logic       r0;
    logic       w0;
    logic [3:0] a0;
    logic [7:0] d0;
    logic       r1;
    logic       w1;
    logic [3:0] a1;
    logic [7:0] d1;
    logic       first;
  } vec_t;

  gnt_exp_t gnt_q[$];
  rd_exp_t  rd_q[$];
  gnt_exp_t g_e;
  rd_exp_t  r_e;

  logic [7:0] mem    [16] = '{default: 8'h00};
  logic [7:0] shadow [16] = '{default: 8'h00};

  int vectors     = 0;
  int miscompares = 0;

  // Memory model: write on mem_wr_en, read data valid the cycle after mem_rd_en.
  always @(posedge clk) begin
    if (bus.mem_wr_en === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd_en === 1'b1) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got an event, want none at %0t", name, $time);
  endtask

  task automatic push_exp(input logic idx, input logic we, input logic [3:0] addr,
                          input logic [7:0] wdata);
    gnt_exp_t g;
    rd_exp_t  r;
    g.idx = idx; g.we = we; g.addr = addr; g.wdata = wdata;
    gnt_q.push_back(g);
    if (we) begin
      shadow[addr] = wdata;
    end else begin
      r.idx  = idx;
      r.data = shadow[addr];
      rd_q.push_back(r);
    end
  endtask

  function automatic vec_t mk(input logic r0, input logic w0, input logic [3:0] a0,
                              input logic [7:0] d0, input logic r1, input logic w1,
                              input logic [3:0] a1, input logic [7:0] d1,
                              input logic first);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.first = first;
    return v;
  endfunction

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (bus.gnt0 === 1'b1 || bus.gnt1 === 1'b1) begin
      chk("gnt_onehot", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
      if (gnt_q.size() == 0) begin
        fail("gnt_unexpected");
      end else begin
        g_e = gnt_q.pop_front();
        chk("sb_gnt_idx", {31'd0, bus.gnt1}, {31'd0, g_e.idx});
        chk("sb_wr_en", {31'd0, bus.mem_wr_en}, {31'd0, g_e.we});
        chk("sb_rd_en", {31'd0, bus.mem_rd_en}, {31'd0, ~g_e.we});
        chk("sb_addr", {28'd0, bus.mem_addr}, {28'd0, g_e.addr});
        if (g_e.we) chk("sb_wdata", {24'd0, bus.mem_wdata}, {24'd0, g_e.wdata});
      end
    end else if (bus.mem_wr_en === 1'b1 || bus.mem_rd_en === 1'b1) begin
      fail("en_without_gnt");
    end
    if (bus.rvalid0 === 1'b1 || bus.rvalid1 === 1'b1) begin
      chk("rvalid_onehot", {31'd0, bus.rvalid0 & bus.rvalid1}, 32'd0);
      if (rd_q.size() == 0) begin
        fail("rvalid_unexpected");
      end else begin
        r_e = rd_q.pop_front();
        chk("sb_rvalid_idx", {31'd0, bus.rvalid1}, {31'd0, r_e.idx});
        chk("sb_rdata", {24'd0, r_e.idx ? bus.rdata1 : bus.rdata0}, {24'd0, r_e.data});
      end
    end
  end

  task automatic drain(input string tag);
    int c;
    c = 0;
    while ((gnt_q.size() != 0 || rd_q.size() != 0) && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_drain"}, gnt_q.size() + rd_q.size(), 32'd0);
    @(negedge clk);
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int pending;
    @(negedge clk);
    bus.req0 = v.r0; bus.we0 = v.w0; bus.addr0 = v.a0; bus.wdata0 = v.d0;
    bus.req1 = v.r1; bus.we1 = v.w1; bus.addr1 = v.a1; bus.wdata1 = v.d1;
    if (!v.first) begin
      if (v.r0) push_exp(1'b0, v.w0, v.a0, v.d0);
      if (v.r1) push_exp(1'b1, v.w1, v.a1, v.d1);
    end else begin
      if (v.r1) push_exp(1'b1, v.w1, v.a1, v.d1);
      if (v.r0) push_exp(1'b0, v.w0, v.a0, v.d0);
    end
    for (int c = 0; c < 40; c++) begin
      if (!(bus.req0 || bus.req1) && gnt_q.size() == 0 && rd_q.size() == 0) break;
      @(negedge clk);
      if (bus.gnt0 === 1'b1) bus.req0 = 1'b0;
      if (bus.gnt1 === 1'b1) bus.req1 = 1'b0;
    end
    pending = gnt_q.size() + rd_q.size() + int'(bus.req0) + int'(bus.req1);
    chk({tag, "_served"}, pending, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [10];
    int   ng;
    logic cur;

    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

    // Simultaneous-request table; `first` traces the round-robin pointer
    // as left by the hand sequences that precede it.
    vt[0] = mk(1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 1'b1, 4'd7,  8'h3C, 1'b1);
    vt[1] = mk(1'b1, 1'b0, 4'd7,  8'h00, 1'b0, 1'b0, 4'd0,  8'h00, 1'b0);
    vt[2] = mk(1'b1, 1'b1, 4'd2,  8'h5A, 1'b1, 1'b0, 4'd2,  8'h00, 1'b1);
    vt[3] = mk(1'b1, 1'b0, 4'd2,  8'h00, 1'b1, 1'b1, 4'd2,  8'hC3, 1'b1);
    vt[4] = mk(1'b1, 1'b0, 4'd5,  8'h00, 1'b1, 1'b0, 4'd6,  8'h00, 1'b1);
    vt[5] = mk(1'b1, 1'b1, 4'd15, 8'hFF, 1'b0, 1'b0, 4'd0,  8'h00, 1'b0);
    vt[6] = mk(1'b1, 1'b1, 4'd0,  8'h01, 1'b1, 1'b1, 4'd15, 8'hEE, 1'b1);
    vt[7] = mk(1'b1, 1'b0, 4'd15, 8'h00, 1'b1, 1'b0, 4'd0,  8'h00, 1'b1);
    vt[8] = mk(1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 1'b0, 4'd3,  8'h00, 1'b1);
    vt[9] = mk(1'b1, 1'b0, 4'd7,  8'h00, 1'b1, 1'b0, 4'd15, 8'h00, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_gnt",    {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    chk("rst_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    chk("rst_rdata",  {16'd0, bus.rdata1, bus.rdata0}, 32'd0);
    chk("rst_en",     {30'd0, bus.mem_rd_en, bus.mem_wr_en}, 32'd0);
    chk("rst_addr",   {28'd0, bus.mem_addr}, 32'd0);
    chk("rst_wdata",  {24'd0, bus.mem_wdata}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single write, requester 0
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd3; bus.wdata0 = 8'hA5;
    push_exp(1'b0, 1'b1, 4'd3, 8'hA5);
    @(negedge clk);
    chk("wr_gnt0",   {31'd0, bus.gnt0}, 32'd1);
    chk("wr_en",     {31'd0, bus.mem_wr_en}, 32'd1);
    chk("wr_addr",   {28'd0, bus.mem_addr}, 32'd3);
    chk("wr_wdata",  {24'd0, bus.mem_wdata}, 32'hA5);
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("wr_idle",      {28'd0, bus.gnt0, bus.gnt1, bus.mem_wr_en, bus.mem_rd_en}, 32'd0);
    chk("wr_hold_addr", {28'd0, bus.mem_addr}, 32'd3);

    // Single read, requester 1, of the same location
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd3; bus.wdata1 = 8'h00;
    push_exp(1'b1, 1'b0, 4'd3, 8'h00);
    @(negedge clk);
    chk("rd_gnt1",  {31'd0, bus.gnt1}, 32'd1);
    chk("rd_en",    {31'd0, bus.mem_rd_en}, 32'd1);
    chk("rd_addr",  {28'd0, bus.mem_addr}, 32'd3);
    bus.req1 = 1'b0;
    @(negedge clk);
    chk("rd_rvalid_n2", {31'd0, bus.rvalid1}, 32'd0);
    @(negedge clk);
    chk("rd_rvalid_n3", {31'd0, bus.rvalid1}, 32'd1);
    chk("rd_rdata_n3",  {24'd0, bus.rdata1}, 32'hA5);
    @(negedge clk);
    chk("rd_rvalid_n4", {31'd0, bus.rvalid1}, 32'd0);
    chk("rd_rdata_hold", {24'd0, bus.rdata1}, 32'hA5);
    drain("single");

    // Contention from reset release: grants alternate 0,1,0,1
    reset = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd5; bus.wdata0 = 8'h11;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 4'd6; bus.wdata1 = 8'h22;
    push_exp(1'b0, 1'b1, 4'd5, 8'h11);
    push_exp(1'b1, 1'b1, 4'd6, 8'h22);
    push_exp(1'b0, 1'b1, 4'd5, 8'h11);
    push_exp(1'b1, 1'b1, 4'd6, 8'h22);
    @(negedge clk);
    reset = 1'b1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge clk);
      if (bus.gnt0 === 1'b1 || bus.gnt1 === 1'b1) begin
        cur = bus.gnt1;
        chk($sformatf("rr_order%0d", ng), {31'd0, cur}, ng % 2);
        ng++;
        if (ng == 4) begin
          bus.req0 = 1'b0;
          bus.req1 = 1'b0;
        end
      end
    end
    chk("rr_grants", ng, 32'd4);
    drain("contention");

    for (int i = 0; i < 10; i++) begin
      apply_vec(vt[i], $sformatf("vec%0d", i));
    end
    drain("table");

    // Late request: req1 rises while requester 0's read sits in RD_WAIT
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd3;
    push_exp(1'b0, 1'b0, 4'd3, 8'h00);
    @(negedge clk);
    chk("late_gnt0", {31'd0, bus.gnt0}, 32'd1);
    bus.req0 = 1'b0;
    @(negedge clk);
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 4'd9; bus.wdata1 = 8'h77;
    push_exp(1'b1, 1'b1, 4'd9, 8'h77);
    @(negedge clk);
    chk("late_rvalid0", {31'd0, bus.rvalid0}, 32'd1);
    chk("late_rdata0",  {24'd0, bus.rdata0}, 32'hA5);
    chk("late_gnt1_n3", {31'd0, bus.gnt1}, 32'd0);
    @(negedge clk);
    chk("late_gnt1_n4", {31'd0, bus.gnt1}, 32'd1);
    bus.req1 = 1'b0;
    drain("late");

    // Reset during RD_WAIT aborts the read
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd9;
    push_exp(1'b0, 1'b0, 4'd9, 8'h00);
    @(negedge clk);
    chk("abort_gnt0", {31'd0, bus.gnt0}, 32'd1);
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("abort_rvalid_n2", {31'd0, bus.rvalid0}, 32'd0);
    reset = 1'b0;
    rd_q.delete();
    @(negedge clk);
    chk("abort_gnt",    {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    chk("abort_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    chk("abort_rdata",  {16'd0, bus.rdata1, bus.rdata0}, 32'd0);
    chk("abort_en",     {30'd0, bus.mem_rd_en, bus.mem_wr_en}, 32'd0);
    chk("abort_addr",   {28'd0, bus.mem_addr}, 32'd0);
    chk("abort_wdata",  {24'd0, bus.mem_wdata}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_no_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    apply_vec(mk(1'b1, 1'b1, 4'd1, 8'hAB, 1'b1, 1'b1, 4'd2, 8'hCD, 1'b0), "post_reset");
    drain("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the data width of both requester ports and the memory port.
REQ-002 The block SHALL have parameter ADDR_W, default 4, giving the address width of both requester ports and the memory port.
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL sample on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 Ports req0/req1, input, 1 bit each: access request from requester 0/1.
REQ-006 Ports we0/we1, input, 1 bit each: 1 = write, 0 = read.
REQ-007 Ports addr0/addr1, input, ADDR_W bits each: requester address.
REQ-008 Ports wdata0/wdata1, input, DATA_W bits each: requester write data.
REQ-009 Ports gnt0/gnt1, output, 1 bit each: one-cycle pulse, high in the cycle the access is issued to memory.
REQ-010 Ports rvalid0/rvalid1, output, 1 bit each: one-cycle pulse marking valid read data.
REQ-011 Ports rdata0/rdata1, output, DATA_W bits each: read data, valid while the matching rvalid is high.
REQ-012 Ports mem_rd_en and mem_wr_en, output, 1 bit each: read and write enables to the memory.
REQ-013 Port mem_addr, output, ADDR_W bits; port mem_wdata, output, DATA_W bits: memory address and write data.
REQ-014 Port mem_rdata, input, DATA_W bits: memory read data, valid in the cycle after mem_rd_en.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCESS and RD_WAIT.
REQ-016 IDLE with no req: the FSM SHALL stay in IDLE, and all enables and pulses SHALL be 0.
REQ-017 IDLE with any req sampled in cycle N: the FSM SHALL pick one winner, register its we, addr and wdata, and enter ACCESS in cycle N+1.
REQ-018 In ACCESS, exactly one of mem_wr_en or mem_rd_en SHALL be high for exactly one cycle, with mem_addr and mem_wdata taken from the registered values, and the winner's gnt SHALL be high in the same cycle.
REQ-019 ACCESS SHALL go to IDLE after a write and to RD_WAIT after a read.
REQ-020 In RD_WAIT, the block SHALL capture mem_rdata into the winner's rdata, pulse that rvalid in cycle N+3, and return to IDLE.
REQ-021 Latency from req sample to gnt SHALL be 1 cycle; latency from req sample to rvalid SHALL be 3 cycles; the next arbitration SHALL occur no earlier than N+2 for a write and N+3 for a read.
REQ-022 Arbitration SHALL be round-robin: a 1-bit priority pointer names the favoured requester, and the pointer SHALL move to the other requester after every grant.
REQ-023 If only one req is high, that requester SHALL win regardless of the pointer.
REQ-024 If both reqs are high in the same cycle, the pointer-favoured requester SHALL win and the other SHALL be served at the next IDLE if it is still requesting.
REQ-025 A req arriving while the FSM is in ACCESS or RD_WAIT SHALL be considered only at the next IDLE; no request SHALL be lost while it is held.
REQ-026 Requesters SHALL hold req, we, addr and wdata stable until their gnt; req still high after gnt SHALL be treated as a new request.
REQ-027 When mem_wr_en and mem_rd_en are low, mem_addr and mem_wdata SHALL hold their last value.
REQ-028 rdata0 and rdata1 SHALL hold their last captured value between rvalid pulses.

Reset
REQ-029 When reset is low at a clock edge, the FSM SHALL go to IDLE, the pointer SHALL favour requester 0, and all outputs (gnt, rvalid, rdata, mem_rd_en, mem_wr_en, mem_addr, mem_wdata) SHALL be 0 in the following cycle.
REQ-030 A reset arriving in ACCESS or RD_WAIT SHALL abort the access; no rvalid SHALL be produced for the aborted read.

Structure
REQ-031 A shared package mem_arb_pkg SHALL hold the state enum (IDLE, ACCESS, RD_WAIT), NUM_REQ=2, and the default DATA_W/ADDR_W constants.
REQ-032 The winner selection SHALL be a sub-module rr_arb2, taking the two reqs and the pointer and returning a winner index and an any-valid flag.

Verification
REQ-033 Single write: req0=1, we0=1, addr0=3, wdata0=8'hA5 at N -> gnt0 and mem_wr_en high at N+1, mem_addr=3, mem_wdata=8'hA5, back in IDLE at N+2.
REQ-034 Single read after that write: req1 read addr1=3 -> gnt1 at N+1, mem_rd_en at N+1, rvalid1=1 and rdata1=8'hA5 at N+3.
REQ-035 Contention: req0 and req1 both held high from reset release -> grants alternate 0,1,0,1, and neither gnt is ever asserted twice in a row.
REQ-036 Late request: req1 rises while requester 0's read is in RD_WAIT -> gnt1 follows at the first ACCESS after IDLE, and no requests are dropped.
REQ-037 Reset mid-read: reset low during RD_WAIT -> no rvalid is produced, all outputs are 0, and a subsequent simultaneous req0/req1 is granted to requester 0 first.
